// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/func constants, ALUOp and PCSrc encodings shared by the control unit.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  function automatic logic fn_known(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL};
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SW, OP_LW,
                      OP_BEQ, OP_BNE, OP_BLEZ, OP_J, OP_HALT};
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps OpCode/func to the ALU operation select.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [2:0] alu_op
);
  always_comb begin
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: alu_op = func == FN_SUB ? ALU_SUB :
                         func == FN_AND ? ALU_AND :
                         func == FN_OR  ? ALU_OR  :
                         func == FN_SLL ? ALU_SLL : ALU_ADD;
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_BEQ, OP_BNE, OP_BLEZ: alu_op = ALU_SUB;
      default:  alu_op = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: single-cycle MIPS-subset main decoder with sticky halt register.
// Optional IllegalOp output enabled by defining CU_ILLEGAL_EN.
module control_unit
  import cpu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       RegWre,
  output logic       InsMemRW,
  output logic       RD,
  output logic       WR,
  output logic       RegDst,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
`ifdef CU_ILLEGAL_EN
  output logic       IllegalOp,
`endif
  output logic [2:0] ALUOp
);
  logic halted, gate, pc_wre, reg_wre, rd, wr;
  logic [1:0] pc_src;

  alu_decoder u_alu_dec (.op(OpCode), .func(func), .alu_op(ALUOp));

  always_ff @(posedge CLK)
    if (Reset) halted <= 1'b0;
    else if (OpCode == OP_HALT) halted <= 1'b1;

  always_comb begin
    pc_wre    = 1'b1;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    reg_wre   = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    RegDst    = 1'b0;
    ExtSel    = 1'b0;
    pc_src    = PC_NEXT;
    case (OpCode)
      OP_RTYPE: begin
        RegDst  = 1'b1;
        reg_wre = fn_known(func);
        ALUSrcA = func == FN_SLL;
      end
      OP_ADDIU, OP_SLTI: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        reg_wre = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ALUSrcB = 1'b1;
        reg_wre = 1'b1;
      end
      OP_SW: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        wr      = 1'b1;
      end
      OP_LW: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        rd        = 1'b1;
        DBDataSrc = 1'b1;
        reg_wre   = 1'b1;
      end
      OP_BEQ: begin
        ExtSel = 1'b1;
        pc_src = zero ? PC_BR : PC_NEXT;
      end
      OP_BNE: begin
        ExtSel = 1'b1;
        pc_src = !zero ? PC_BR : PC_NEXT;
      end
      OP_BLEZ: begin
        ExtSel = 1'b1;
        pc_src = (sign | zero) ? PC_BR : PC_NEXT;
      end
      OP_J:    pc_src = PC_JMP;
      OP_HALT: pc_wre = 1'b0;
      default: pc_wre = 1'b1;
    endcase
  end

  // reset level and the sticky halt both freeze every state-changing strobe
  assign gate     = Reset | halted;
  assign PCWre    = pc_wre & ~gate;
  assign RegWre   = reg_wre & ~gate;
  assign RD       = rd & ~gate;
  assign WR       = wr & ~gate;
  assign PCSrc    = gate ? PC_NEXT : pc_src;
  assign InsMemRW = 1'b1;

`ifdef CU_ILLEGAL_EN
  assign IllegalOp = !op_known(OpCode) | (OpCode == OP_RTYPE & !fn_known(func));
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven, scoreboard-checked bench for control_unit.
module tb_control_unit;
`ifdef CU_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        s;
    logic        r;
    logic [15:0] e;
  } vec_t;

  logic CLK = 1'b0, Reset = 1'b1, zero = 1'b0, sign = 1'b0;
  logic [5:0] OpCode = '0, func = '0;
  logic PCWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, InsMemRW, RD, WR, RegDst, ExtSel, ill;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[$];
  vec_t sb[$];

  always #5 CLK = ~CLK;

  control_unit dut (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .func(func), .zero(zero), .sign(sign),
    .PCWre(PCWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .RegWre(RegWre), .InsMemRW(InsMemRW), .RD(RD), .WR(WR), .RegDst(RegDst),
    .ExtSel(ExtSel), .PCSrc(PCSrc),
`ifdef CU_ILLEGAL_EN
    .IllegalOp(ill),
`endif
    .ALUOp(ALUOp)
  );
`ifndef CU_ILLEGAL_EN
  assign ill = 1'b0;
`endif

  function automatic logic [15:0] o(input bit pcw, asa, asb, dbs, rw, rd, wr, rdst, ext,
                                    input logic [1:0] pcs, input logic [2:0] alu, input bit il);
    return {il & ILL, pcw, asa, asb, dbs, rw, 1'b1, rd, wr, rdst, ext, pcs, alu};
  endfunction

  function automatic vec_t mk(input string nm, input logic [5:0] op, fn, input logic z, s, r,
                              input logic [15:0] e);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.s = s; v.r = r; v.e = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t x;
    logic [15:0] act;
    @(posedge CLK);
    #1;
    OpCode = v.op; func = v.fn; zero = v.z; sign = v.s; Reset = v.r;
    sb.push_back(v);
    @(negedge CLK);
    x = sb.pop_front();
    act = {ill, PCWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, InsMemRW, RD, WR, RegDst, ExtSel, PCSrc, ALUOp};
    n_cmp++;
    if (act !== x.e) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", x.nm, act, x.e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv.push_back(mk("add",     6'b000000, 6'b100000, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b000,0)));
    tv.push_back(mk("sub",     6'b000000, 6'b100010, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b001,0)));
    tv.push_back(mk("and",     6'b000000, 6'b100100, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b100,0)));
    tv.push_back(mk("or",      6'b000000, 6'b100101, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b011,0)));
    tv.push_back(mk("sll",     6'b000000, 6'b000000, 0, 0, 0, o(1,1,0,0,1,0,0,1,0,2'b00,3'b010,0)));
    tv.push_back(mk("badfn",   6'b000000, 6'b101010, 0, 0, 0, o(1,0,0,0,0,0,0,1,0,2'b00,3'b000,1)));
    tv.push_back(mk("addiu",   6'b001001, 6'b100010, 0, 0, 0, o(1,0,1,0,1,0,0,0,1,2'b00,3'b000,0)));
    tv.push_back(mk("andi",    6'b001100, 6'b000000, 0, 0, 0, o(1,0,1,0,1,0,0,0,0,2'b00,3'b100,0)));
    tv.push_back(mk("ori",     6'b001101, 6'b100100, 0, 0, 0, o(1,0,1,0,1,0,0,0,0,2'b00,3'b011,0)));
    tv.push_back(mk("slti",    6'b001010, 6'b000000, 0, 0, 0, o(1,0,1,0,1,0,0,0,1,2'b00,3'b110,0)));
    tv.push_back(mk("sw",      6'b101011, 6'b000000, 0, 0, 0, o(1,0,1,0,0,0,1,0,1,2'b00,3'b000,0)));
    tv.push_back(mk("lw",      6'b100011, 6'b000000, 0, 0, 0, o(1,0,1,1,1,1,0,0,1,2'b00,3'b000,0)));
    tv.push_back(mk("beq_z1",  6'b000100, 6'b000000, 1, 0, 0, o(1,0,0,0,0,0,0,0,1,2'b01,3'b001,0)));
    tv.push_back(mk("beq_z0",  6'b000100, 6'b000000, 0, 1, 0, o(1,0,0,0,0,0,0,0,1,2'b00,3'b001,0)));
    tv.push_back(mk("bne_z0",  6'b000101, 6'b000000, 0, 0, 0, o(1,0,0,0,0,0,0,0,1,2'b01,3'b001,0)));
    tv.push_back(mk("bne_z1",  6'b000101, 6'b000000, 1, 0, 0, o(1,0,0,0,0,0,0,0,1,2'b00,3'b001,0)));
    tv.push_back(mk("blez_s",  6'b000110, 6'b000000, 0, 1, 0, o(1,0,0,0,0,0,0,0,1,2'b01,3'b001,0)));
    tv.push_back(mk("blez_z",  6'b000110, 6'b000000, 1, 0, 0, o(1,0,0,0,0,0,0,0,1,2'b01,3'b001,0)));
    tv.push_back(mk("blez_0",  6'b000110, 6'b000000, 0, 0, 0, o(1,0,0,0,0,0,0,0,1,2'b00,3'b001,0)));
    tv.push_back(mk("j",       6'b000010, 6'b000000, 1, 1, 0, o(1,0,0,0,0,0,0,0,0,2'b10,3'b000,0)));
    tv.push_back(mk("undef",   6'b111110, 6'b100000, 0, 0, 0, o(1,0,0,0,0,0,0,0,0,2'b00,3'b000,1)));
    tv.push_back(mk("rst_lw",  6'b100011, 6'b000000, 0, 0, 1, o(0,0,1,1,0,0,0,0,1,2'b00,3'b000,0)));
    tv.push_back(mk("rst_beq", 6'b000100, 6'b000000, 1, 0, 1, o(0,0,0,0,0,0,0,0,1,2'b00,3'b001,0)));
    tv.push_back(mk("rst_j",   6'b000010, 6'b000000, 0, 0, 1, o(0,0,0,0,0,0,0,0,0,2'b00,3'b000,0)));

    apply(mk("reset_add", 6'b000000, 6'b100000, 0, 0, 1, o(0,0,0,0,0,0,0,1,0,2'b00,3'b000,0)));
    apply(mk("post_rst_add", 6'b000000, 6'b100000, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b000,0)));
    foreach (tv[i]) apply(tv[i]);

    apply(mk("halt",        6'b111111, 6'b000000, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,2'b00,3'b000,0)));
    apply(mk("halted_add",  6'b000000, 6'b100000, 0, 0, 0, o(0,0,0,0,0,0,0,1,0,2'b00,3'b000,0)));
    apply(mk("halted_j",    6'b000010, 6'b000000, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,2'b00,3'b000,0)));
    apply(mk("halted_lw",   6'b100011, 6'b000000, 0, 0, 0, o(0,0,1,1,0,0,0,0,1,2'b00,3'b000,0)));
    apply(mk("halted_beq",  6'b000100, 6'b000000, 1, 0, 0, o(0,0,0,0,0,0,0,0,1,2'b00,3'b001,0)));
    apply(mk("unhalt_rst",  6'b000000, 6'b100000, 0, 0, 1, o(0,0,0,0,0,0,0,1,0,2'b00,3'b000,0)));
    apply(mk("unhalt_add",  6'b000000, 6'b100000, 0, 0, 0, o(1,0,0,0,1,0,0,1,0,2'b00,3'b000,0)));
    apply(mk("rst_halt",    6'b111111, 6'b000000, 0, 0, 1, o(0,0,0,0,0,0,0,0,0,2'b00,3'b000,0)));
    apply(mk("rst_wins_sw", 6'b101011, 6'b000000, 0, 0, 0, o(1,0,1,0,0,0,1,0,1,2'b00,3'b000,0)));
    apply(mk("rst_wins_j",  6'b000010, 6'b000000, 0, 0, 0, o(1,0,0,0,0,0,0,0,0,2'b10,3'b000,0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
